cvxif_dotp_accel: RTL and testbench
===================================

Name: cvxif_dotp_accel

Overview:
- Parametrised packed dot-product MAC engine behind the CV-X-IF coprocessor's decoder and commit FIFO.
- Accepts decoded ops over a valid/ready handshake and runs a 2-stage multiply/accumulate pipeline into NR_ACC selectable accumulators.
- Holds an operand buffer that can record rs1 streams and replay them later.
- Returns accumulator reads through a valid/ready result port, which the wrapper maps onto the X-IF result interface.

Parameters:
- XLEN, 32, operand and result width.
- LANE_W, 8, lane width; NLANES = XLEN/LANE_W; XLEN must be divisible by LANE_W.
- NR_ACC, 4, number of independent accumulators.
- BUF_DEPTH, 128, operand buffer entries; power of two.
- ID_W, 4, instruction id width.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- op_valid_i  in  1  op offered
- op_ready_o  out  1  op accepted when valid and ready are both high
- op_i  in  2  operation: 0 MAC, 1 READ, 2 READ_CLR, 3 CFG
- acc_sel_i  in  $clog2(NR_ACC)  target accumulator
- mode_i  in  2  signedness {rs1_signed, rs2_signed}
- rs1_i  in  XLEN  operand A / CFG payload
- rs2_i  in  XLEN  operand B
- id_i  in  ID_W  instruction id
- kill_i  in  1  flush all in-flight ops
- res_valid_o  out  1  result available
- res_ready_i  in  1  result consumed
- res_data_o  out  XLEN  result data
- res_id_o  out  ID_W  id of the op that produced the result

Behaviour:
- Reset values:
  - all accumulators 0; buffer pointer 0; buffer contents are don't-care;
  - mode = RECORD; pipeline valids 0;
  - res_valid_o=0, res_data_o=0, res_id_o=0, op_ready_o=1.
- Lanes:
  - each lane is extended to LANE_W+1 bits, signed or unsigned per mode_i;
  - lane products are 2*LANE_W+2 bits, sign-extended to XLEN.
- MAC pipeline:
  - Accept cycle t: operand A = (mode==REPLAY) ? buf[ptr] : rs1_i.
  - In RECORD mode, buf[ptr] <= rs1_i on the accept edge.
  - ptr increments on every accepted MAC and wraps BUF_DEPTH-1 -> 0.
  - t+1: lane products registered (stage 1).
  - t+2: acc[acc_sel] += sum of products (stage 2), modulo 2^XLEN.
  - Throughput is 1 MAC/cycle; back-to-back MACs to the same accumulator must accumulate correctly.
  - MAC produces no result.
- READ / READ_CLR:
  - Accepted only when both pipeline stages are empty and res_valid_o=0; otherwise op_ready_o=0.
  - At t+1: res_valid_o=1, res_data_o = acc[acc_sel], res_id_o = id_i, ptr <= 0.
  - READ_CLR additionally sets acc[acc_sel] <= 0 on the same edge.
- Result hold: res_valid_o and the result data/id stay stable until res_valid_o && res_ready_i.
- CFG:
  - rs1_i[0] = 1 selects RECORD, 0 selects REPLAY; ptr <= 0.
  - No result.
  - Accepted when the pipeline is empty; applies to the next MAC.
- op_ready_o = !(res_valid_o && !res_ready_i) && !(op_i in {READ, READ_CLR, CFG} && pipeline busy).
  - op_ready_o is combinational from state and op_i.
- kill_i:
  - clears both stage valids and res_valid_o on the next edge;
  - a MAC already in stage 2 still completes its accumulation;
  - op_ready_o is 0 during the kill cycle;
  - accumulators, ptr, mode and buffer contents are kept.
- Simultaneous op accept and result drain: allowed in the same cycle.
- Reset asserted mid-operation aborts everything immediately and all state returns to reset values.

Optional Feature:
- Macro: CVXIF_DOTP_SAT_EN.
- Defined: stage 2 saturates signed to [0x80000000, 0x7FFFFFFF] (XLEN-generic min/max); a sticky per-accumulator overflow flag is returned in the READ result's... not applicable; the flag is cleared by READ_CLR and is unobservable on ports.
- Undefined: two's-complement wrap; no saturation logic is synthesised.

Decomposition:
- Shared package cvxif_dotp_pkg holds:
  - the op_e enum (MAC/READ/READ_CLR/CFG);
  - the buf_mode_e enum (RECORD/REPLAY);
  - the stage-1 payload struct (products, acc_sel, valid);
  - the lane-count function.
- One sub-module: dotp_lane_mul (single lane, signedness-configurable multiply), instantiated NLANES times with a generate loop.

Test Plan:
- mode=01 (A unsigned, B signed), MAC rs1=0x01020304, rs2=0xFFFFFFFF to acc0, then READ -> res_data_o=0xFFFFFFF6; READ accepted no earlier than 2 cycles after the MAC.
- mode=11, MAC 0x80808080 x 0x80808080 to acc1; mode=00, MAC 0xFFFFFFFF x 0xFFFFFFFF to acc2; READ both -> 0x00010000 and 0x0003F804; acc0 and acc3 remain 0.
- Back-to-back MACs: 8257 MACs of 0xFFFFFFFF x 0xFFFFFFFF in mode 00 to acc3, then READ -> 0x80027904 without the macro, 0x7FFFFFFF with CVXIF_DOTP_SAT_EN.
- Buffer replay:
  - CFG rs1=1, then 4 MACs with rs1=0x01010101..0x04040404, rs2=0x01010101, then READ_CLR -> 40;
  - CFG rs1=0, then the same 4 MACs with rs1=0xDEADBEEF, then READ -> 40.
- Backpressure: hold res_ready_i=0 for 5 cycles after a READ -> res_valid_o, res_data_o and res_id_o stay stable and op_ready_o=0; release -> a new op is accepted in the same cycle.
- Assert kill_i one cycle after a MAC is accepted -> that MAC has no effect on its accumulator and res_valid_o drops.
- Assert rst_ni=0 with MACs in flight -> accumulators read 0 after reset and op_ready_o=1.

Source files
------------

// File: rtl/cvxif_dotp_pkg.sv
// Shared types for the CV-X-IF packed dot-product accelerator.
// Optional saturation is enabled with CVXIF_DOTP_SAT_EN.
package cvxif_dotp_pkg;

  typedef enum logic [1:0] {
    OP_MAC      = 2'd0,
    OP_READ     = 2'd1,
    OP_READ_CLR = 2'd2,
    OP_CFG      = 2'd3
  } op_e;

  typedef enum logic {
    BUF_RECORD = 1'b0,
    BUF_REPLAY = 1'b1
  } buf_mode_e;

  function automatic int lane_count(input int xlen, input int lane_w);
    return xlen / lane_w;
  endfunction

endpackage

// File: rtl/dotp_lane_mul.sv
// One packed lane multiply with per-operand signedness.
// Product is sign-extended to the datapath width.
module dotp_lane_mul #(
  parameter int LANE_W = 8,
  parameter int XLEN   = 32
) (
  input  logic [LANE_W-1:0] a,
  input  logic [LANE_W-1:0] b,
  input  logic              a_signed,
  input  logic              b_signed,
  output logic [XLEN-1:0]   prod
);

  localparam int PW = 2 * LANE_W + 2;

  logic signed [LANE_W:0] ax;
  logic signed [LANE_W:0] bx;
  logic signed [PW-1:0]   p;

  assign ax = {a_signed & a[LANE_W-1], a};
  assign bx = {b_signed & b[LANE_W-1], b};
  assign p  = PW'(ax) * PW'(bx);
  assign prod = XLEN'(p);

endmodule

// File: rtl/cvxif_dotp_accel.sv
// Packed dot-product MAC engine with operand record/replay buffer.
// Define CVXIF_DOTP_SAT_EN for signed saturating accumulation.
module cvxif_dotp_accel
  import cvxif_dotp_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int LANE_W    = 8,
  parameter int NR_ACC    = 4,
  parameter int BUF_DEPTH = 128,
  parameter int ID_W      = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      op_valid_i,
  output logic                      op_ready_o,
  input  logic [1:0]                op_i,
  input  logic [$clog2(NR_ACC)-1:0] acc_sel_i,
  input  logic [1:0]                mode_i,
  input  logic [XLEN-1:0]           rs1_i,
  input  logic [XLEN-1:0]           rs2_i,
  input  logic [ID_W-1:0]           id_i,
  input  logic                      kill_i,
  output logic                      res_valid_o,
  input  logic                      res_ready_i,
  output logic [XLEN-1:0]           res_data_o,
  output logic [ID_W-1:0]           res_id_o
);

  localparam int NLANES = lane_count(XLEN, LANE_W);
  localparam int SW     = $clog2(NR_ACC);
  localparam int PTR_W  = $clog2(BUF_DEPTH);

  typedef struct packed {
    logic [NLANES-1:0][XLEN-1:0] prod;
    logic [SW-1:0]               sel;
    logic                        valid;
  } s1_t;

  s1_t                         s1_q;
  logic                        s2_valid_q;
  logic [SW-1:0]               s2_sel_q;
  logic [XLEN-1:0]             s2_sum_q;
  logic [XLEN-1:0]             acc_q [NR_ACC];
  logic [XLEN-1:0]             opbuf_q [BUF_DEPTH];
  logic [PTR_W-1:0]            ptr_q;
  buf_mode_e                   mode_q;

  op_e                         op;
  logic                        is_mac;
  logic                        is_read;
  logic                        busy;
  logic                        accept;
  logic [XLEN-1:0]             opa;
  logic [NLANES-1:0][XLEN-1:0] prod;
  logic [XLEN-1:0]             sum;
  logic [XLEN-1:0]             acc_cur;
  logic [XLEN-1:0]             acc_nxt;

  assign op      = op_e'(op_i);
  assign is_mac  = (op == OP_MAC);
  assign busy    = s1_q.valid | s2_valid_q;
  // Non-MAC ops must see a drained pipeline so reads return settled sums.
  assign op_ready_o = !kill_i
                   && !(res_valid_o && !res_ready_i)
                   && !(!is_mac && busy);
  assign accept  = op_valid_i && op_ready_o;
  assign is_read = accept && (op == OP_READ || op == OP_READ_CLR);
  assign opa     = (mode_q == BUF_REPLAY) ? opbuf_q[ptr_q] : rs1_i;

  for (genvar g = 0; g < NLANES; g++) begin : g_lane
    dotp_lane_mul #(
      .LANE_W(LANE_W),
      .XLEN  (XLEN)
    ) u_mul (
      .a       (opa[g*LANE_W +: LANE_W]),
      .b       (rs2_i[g*LANE_W +: LANE_W]),
      .a_signed(mode_i[1]),
      .b_signed(mode_i[0]),
      .prod    (prod[g])
    );
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < NLANES; i++) begin
      sum = sum + s1_q.prod[i];
    end
  end

`ifdef CVXIF_DOTP_SAT_EN
  logic [XLEN:0]     wide;
  logic              ovf;
  logic [NR_ACC-1:0] ovf_q;

  always_comb begin
    acc_cur = acc_q[s2_sel_q];
    wide    = {acc_cur[XLEN-1], acc_cur} + {s2_sum_q[XLEN-1], s2_sum_q};
    ovf     = wide[XLEN] ^ wide[XLEN-1];
    acc_nxt = wide[XLEN-1:0];
    if (ovf) begin
      acc_nxt = wide[XLEN] ? {1'b1, {(XLEN-1){1'b0}}}
                           : {1'b0, {(XLEN-1){1'b1}}};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ovf_q <= '0;
    end else if (s2_valid_q && ovf) begin
      ovf_q[s2_sel_q] <= 1'b1;
    end else if (is_read && op == OP_READ_CLR) begin
      ovf_q[acc_sel_i] <= 1'b0;
    end
  end
`else
  always_comb begin
    acc_cur = acc_q[s2_sel_q];
    acc_nxt = acc_cur + s2_sum_q;
  end
`endif

  // Stage 2 finishes even under kill; only younger work is dropped.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NR_ACC; i++) begin
        acc_q[i] <= '0;
      end
    end else if (s2_valid_q) begin
      acc_q[s2_sel_q] <= acc_nxt;
    end else if (is_read && op == OP_READ_CLR) begin
      acc_q[acc_sel_i] <= '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q       <= '0;
      s2_valid_q <= 1'b0;
      s2_sel_q   <= '0;
      s2_sum_q   <= '0;
      ptr_q      <= '0;
      mode_q     <= BUF_RECORD;
    end else begin
      s1_q.valid <= accept && is_mac;
      if (accept && is_mac) begin
        s1_q.prod <= prod;
        s1_q.sel  <= acc_sel_i;
      end
      s2_valid_q <= s1_q.valid && !kill_i;
      if (s1_q.valid) begin
        s2_sel_q <= s1_q.sel;
        s2_sum_q <= sum;
      end
      if (accept) begin
        unique case (op)
          OP_MAC: ptr_q <= ptr_q + PTR_W'(1);
          OP_CFG: begin
            ptr_q  <= '0;
            mode_q <= rs1_i[0] ? BUF_RECORD : BUF_REPLAY;
          end
          default: ptr_q <= '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept && is_mac && mode_q == BUF_RECORD) begin
      opbuf_q[ptr_q] <= rs1_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      res_valid_o <= 1'b0;
      res_data_o  <= '0;
      res_id_o    <= '0;
    end else if (kill_i) begin
      res_valid_o <= 1'b0;
    end else if (is_read) begin
      res_valid_o <= 1'b1;
      res_data_o  <= acc_q[acc_sel_i];
      res_id_o    <= id_i;
    end else if (res_ready_i) begin
      res_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cvxif_dotp_accel.sv
// Bench for cvxif_dotp_accel: directed literals plus random ops
// checked every cycle against a transaction-level model.
module tb_cvxif_dotp_accel;

  localparam logic [1:0] MAC = 2'd0;
  localparam logic [1:0] RD  = 2'd1;
  localparam logic [1:0] RDC = 2'd2;
  localparam logic [1:0] CFG = 2'd3;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b1;
  logic        op_valid_i = 1'b0;
  logic        op_ready_o;
  logic [1:0]  op_i = 2'd0;
  logic [1:0]  acc_sel_i = 2'd0;
  logic [1:0]  mode_i = 2'd0;
  logic [31:0] rs1_i = '0;
  logic [31:0] rs2_i = '0;
  logic [3:0]  id_i = '0;
  logic        kill_i = 1'b0;
  logic        res_valid_o;
  logic        res_ready_i = 1'b0;
  logic [31:0] res_data_o;
  logic [3:0]  res_id_o;

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          last_acc = 0;
  logic [3:0]  next_id = 4'd0;

  cvxif_dotp_accel dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .op_valid_i (op_valid_i),
    .op_ready_o (op_ready_o),
    .op_i       (op_i),
    .acc_sel_i  (acc_sel_i),
    .mode_i     (mode_i),
    .rs1_i      (rs1_i),
    .rs2_i      (rs2_i),
    .id_i       (id_i),
    .kill_i     (kill_i),
    .res_valid_o(res_valid_o),
    .res_ready_i(res_ready_i),
    .res_data_o (res_data_o),
    .res_id_o   (res_id_o)
  );

  initial forever #5 clk_i = ~clk_i;
  initial forever begin
    @(posedge clk_i);
    cyc++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish, %0d errors so far", n_err);
    $fatal(1);
  end

  function automatic void chk(input string nm, input logic [31:0] got,
                              input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, got, exp, cyc);
    end
  endfunction

  // ---------------- reference model ----------------
  typedef struct {
    int          sel;
    logic [31:0] val;
    int          age;
  } fl_t;

  logic [31:0] m_acc [4];
  logic [31:0] m_buf [128];
  int          m_ptr;
  bit          m_replay;
  fl_t         m_fl[$];
  bit          m_rv;
  logic [31:0] m_rd;
  logic [3:0]  m_rid;

  function automatic logic [31:0] dotp(input logic [31:0] a,
                                       input logic [31:0] b,
                                       input logic [1:0] m);
    int s;
    s = 0;
    for (int i = 0; i < 4; i++) begin
      logic [7:0] la;
      logic [7:0] lb;
      int x;
      int y;
      la = a[8*i +: 8];
      lb = b[8*i +: 8];
      x = m[1] ? int'($signed(la)) : int'(la);
      y = m[0] ? int'($signed(lb)) : int'(lb);
      s += x * y;
    end
    return s;
  endfunction

  function automatic logic [31:0] add_acc(input logic [31:0] a,
                                          input logic [31:0] v);
`ifdef CVXIF_DOTP_SAT_EN
    longint t;
    t = longint'($signed(a)) + longint'($signed(v));
    if (t > 64'sd2147483647) return 32'h7FFFFFFF;
    if (t < -64'sd2147483648) return 32'h80000000;
    return t[31:0];
`else
    return a + v;
`endif
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) m_acc[i] = '0;
    m_ptr = 0;
    m_replay = 1'b0;
    m_fl.delete();
    m_rv = 1'b0;
    m_rd = '0;
    m_rid = '0;
  endfunction

  function automatic void model_step(input bit acc_ok);
    fl_t nq[$];
    fl_t e;
    logic [31:0] a;
    if (kill_i) m_rv = 1'b0;
    else if (acc_ok && (op_i == RD || op_i == RDC)) begin
      m_rv = 1'b1;
      m_rd = m_acc[acc_sel_i];
      m_rid = id_i;
    end else if (res_ready_i) m_rv = 1'b0;
    foreach (m_fl[i]) begin
      if (m_fl[i].age == 1) m_acc[m_fl[i].sel] = add_acc(m_acc[m_fl[i].sel], m_fl[i].val);
      else if (!kill_i) begin
        e = m_fl[i];
        e.age = 1;
        nq.push_back(e);
      end
    end
    m_fl = nq;
    if (acc_ok) begin
      case (op_i)
        MAC: begin
          a = m_replay ? m_buf[m_ptr] : rs1_i;
          if (!m_replay) m_buf[m_ptr] = rs1_i;
          e.sel = int'(acc_sel_i);
          e.val = dotp(a, rs2_i, mode_i);
          e.age = 0;
          m_fl.push_back(e);
          m_ptr = (m_ptr + 1) % 128;
        end
        RD: m_ptr = 0;
        RDC: begin
          m_ptr = 0;
          m_acc[acc_sel_i] = '0;
        end
        default: begin
          m_ptr = 0;
          m_replay = !rs1_i[0];
        end
      endcase
    end
  endfunction

  // One compare process: outputs vs model every cycle, then advance model.
  initial begin
    bit exp_rdy;
    model_reset();
    forever begin
      @(negedge clk_i);
      if (!rst_ni) model_reset();
      chk("res_valid", 32'(res_valid_o), 32'(m_rv));
      if (m_rv || !rst_ni) begin
        chk("res_data", res_data_o, m_rd);
        chk("res_id", 32'(res_id_o), 32'(m_rid));
      end
      exp_rdy = !kill_i && !(m_rv && !res_ready_i) && !(op_i != MAC && m_fl.size() != 0);
      chk("op_ready", 32'(op_ready_o), 32'(exp_rdy));
      if (rst_ni) model_step(op_valid_i && exp_rdy);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [1:0] op, input logic [1:0] sel,
                       input logic [1:0] m, input logic [31:0] a,
                       input logic [31:0] b);
    bit ok;
    int n;
    ok = 1'b0;
    n = 0;
    op_valid_i = 1'b1;
    op_i = op;
    acc_sel_i = sel;
    mode_i = m;
    rs1_i = a;
    rs2_i = b;
    id_i = next_id;
    while (!ok && n < 100) begin
      @(negedge clk_i);
      ok = op_ready_o;
      @(posedge clk_i);
      #1;
      n++;
    end
    chk("issue_accept", 32'(ok), 32'd1);
    last_acc = cyc;
    next_id++;
    op_valid_i = 1'b0;
  endtask

  task automatic read_chk(input logic [1:0] op, input logic [1:0] sel,
                          input logic [31:0] expv, input string nm);
    logic [3:0] id;
    int n;
    id = next_id;
    n = 0;
    res_ready_i = 1'b0;
    issue(op, sel, 2'b00, 32'h0, 32'h0);
    while (!res_valid_o && n < 20) begin
      @(posedge clk_i);
      #1;
      n++;
    end
    chk({nm, "_valid"}, 32'(res_valid_o), 32'd1);
    chk(nm, res_data_o, expv);
    chk({nm, "_id"}, 32'(res_id_o), 32'(id));
    res_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    res_ready_i = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int c_mac;
    logic [3:0] bp_id;
    int r;

    #2 rst_ni = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("reset_ready", 32'(op_ready_o), 32'd1);
    chk("reset_res_valid", 32'(res_valid_o), 32'd0);
    @(posedge clk_i);
    #1;

    // Mixed signedness: unsigned A, signed B.
    issue(MAC, 2'd0, 2'b01, 32'h01020304, 32'hFFFFFFFF);
    c_mac = last_acc;
    read_chk(RD, 2'd0, 32'hFFFFFFF6, "t1_read");
    chk("t1_read_gap", 32'((last_acc - c_mac) >= 2), 32'd1);
    read_chk(RDC, 2'd0, 32'hFFFFFFF6, "t1_readclr");

    issue(MAC, 2'd1, 2'b11, 32'h80808080, 32'h80808080);
    issue(MAC, 2'd2, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF);
    read_chk(RD, 2'd1, 32'h00010000, "t2_acc1");
    read_chk(RD, 2'd2, 32'h0003F804, "t2_acc2");
    read_chk(RD, 2'd0, 32'h0, "t2_acc0");
    read_chk(RD, 2'd3, 32'h0, "t2_acc3");
    read_chk(RDC, 2'd1, 32'h00010000, "t2_clr1");
    read_chk(RDC, 2'd2, 32'h0003F804, "t2_clr2");

    // Back-to-back accumulation past the signed boundary.
    for (int i = 0; i < 8257; i++) begin
      issue(MAC, 2'd3, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF);
    end
`ifdef CVXIF_DOTP_SAT_EN
    read_chk(RDC, 2'd3, 32'h7FFFFFFF, "t3_b2b");
`else
    read_chk(RDC, 2'd3, 32'h80027904, "t3_b2b");
`endif

    // Record then replay.
    issue(CFG, 2'd0, 2'b00, 32'h1, 32'h0);
    for (int i = 1; i <= 4; i++) begin
      issue(MAC, 2'd0, 2'b00, 32'h01010101 * i, 32'h01010101);
    end
    read_chk(RDC, 2'd0, 32'd40, "t4_record");
    issue(CFG, 2'd0, 2'b00, 32'h0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      issue(MAC, 2'd0, 2'b00, 32'hDEADBEEF, 32'h01010101);
    end
    read_chk(RDC, 2'd0, 32'd40, "t4_replay");
    issue(CFG, 2'd0, 2'b00, 32'h1, 32'h0);

    // Result backpressure with a MAC waiting behind it.
    bp_id = next_id;
    res_ready_i = 1'b0;
    issue(RD, 2'd1, 2'b00, 32'h0, 32'h0);
    op_valid_i = 1'b1;
    op_i = MAC;
    acc_sel_i = 2'd1;
    mode_i = 2'b00;
    rs1_i = 32'h01010101;
    rs2_i = 32'h02020202;
    repeat (5) begin
      @(negedge clk_i);
      chk("bp_valid", 32'(res_valid_o), 32'd1);
      chk("bp_data", res_data_o, 32'h0);
      chk("bp_id", 32'(res_id_o), 32'(bp_id));
      chk("bp_ready", 32'(op_ready_o), 32'd0);
      @(posedge clk_i);
      #1;
    end
    res_ready_i = 1'b1;
    @(negedge clk_i);
    chk("bp_release_ready", 32'(op_ready_o), 32'd1);
    @(posedge clk_i);
    #1;
    op_valid_i = 1'b0;
    res_ready_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    read_chk(RDC, 2'd1, 32'd8, "bp_mac_taken");

    // Kill while the MAC is in stage 1: dropped.
    issue(MAC, 2'd2, 2'b00, 32'h01010101, 32'h01010101);
    kill_i = 1'b1;
    @(negedge clk_i);
    chk("kill_ready", 32'(op_ready_o), 32'd0);
    @(posedge clk_i);
    #1;
    kill_i = 1'b0;
    read_chk(RD, 2'd2, 32'h0, "kill_s1_acc");

    // Kill drops a pending result.
    res_ready_i = 1'b0;
    issue(RD, 2'd0, 2'b00, 32'h0, 32'h0);
    kill_i = 1'b1;
    @(posedge clk_i);
    #1;
    kill_i = 1'b0;
    chk("kill_res_valid", 32'(res_valid_o), 32'd0);

    // Kill while the MAC is in stage 2: it still lands.
    issue(MAC, 2'd2, 2'b00, 32'h01010101, 32'h01010101);
    @(posedge clk_i);
    #1;
    kill_i = 1'b1;
    @(posedge clk_i);
    #1;
    kill_i = 1'b0;
    read_chk(RDC, 2'd2, 32'd4, "kill_s2_acc");

    // Reset with MACs in flight.
    for (int i = 0; i < 4; i++) begin
      issue(MAC, 2'(i), 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF);
    end
    rst_ni = 1'b0;
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("rst_ready", 32'(op_ready_o), 32'd1);
    @(posedge clk_i);
    #1;
    for (int i = 0; i < 4; i++) begin
      read_chk(RD, 2'(i), 32'h0, "rst_acc");
    end

    // Fill the whole buffer so random replay reads defined data.
    issue(CFG, 2'd0, 2'b00, 32'h1, 32'h0);
    for (int i = 0; i < 128; i++) begin
      issue(MAC, 2'd0, 2'(i), $urandom, $urandom);
    end
    res_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      issue(RDC, 2'(i), 2'b00, 32'h0, 32'h0);
    end

    // Random traffic, checked by the compare process.
    repeat (3000) begin
      r = $urandom_range(0, 99);
      op_valid_i = ($urandom_range(0, 3) != 0);
      op_i = (r < 55) ? MAC : (r < 70) ? RD : (r < 80) ? RDC : CFG;
      acc_sel_i = 2'($urandom_range(0, 3));
      mode_i = 2'($urandom_range(0, 3));
      rs1_i = $urandom;
      rs2_i = $urandom;
      id_i = 4'($urandom_range(0, 15));
      res_ready_i = ($urandom_range(0, 9) < 7);
      kill_i = ($urandom_range(0, 49) == 0);
      @(posedge clk_i);
      #1;
    end
    op_valid_i = 1'b0;
    kill_i = 1'b0;
    res_ready_i = 1'b1;
    repeat (5) @(posedge clk_i);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
